// File: rtl/pwm_digit_scan.sv
// Binary-to-BCD converter (sequential shift-add-3) with a multiplexed digit scanner feeding a 7-segment decoder.
// Optional build macro LEADING_ZERO_BLANK_EN: blank zero digits above the most significant nonzero digit.
module pwm_digit_scan #(
  parameter int WIDTH       = 7,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  value_in,
  output logic              busy,
  output logic [3:0]        bin_data,
  output logic              ena,
  output logic [DIGITS-1:0] dig_an
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned LIMIT = pow10(DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_shift;
  logic            r_ovf_pend;
  logic [BW-1:0]   r_disp;
  logic            r_disp_ovf;
  logic            r_busy;
  logic [RW-1:0]   r_refresh;
  logic [DW-1:0]   r_digit;
  logic [3:0]      r_bin;
  logic            r_ena;
  logic [DIGITS-1:0] r_an;

  logic [SW-1:0]   w_adj;
  logic            w_ovf;
  logic [DW-1:0]   w_next;
  logic [3:0]      w_nib;
  logic            w_blank_sel;
  logic [3:0]      w_code;

  assign w_ovf = (64'(value_in) >= LIMIT);

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    w_adj = r_shift;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_shift[WIDTH + 4*d +: 4] >= 4'd5)
        w_adj[WIDTH + 4*d +: 4] = r_shift[WIDTH + 4*d +: 4] + 4'd3;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;
  logic              w_lead;

  // Walk from the top digit down; digit 0 is never blanked.
  always_comb begin
    w_blank = '0;
    w_lead  = 1'b1;
    for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
      w_lead = w_lead && (r_shift[WIDTH + 4*(DIGITS-1-k) +: 4] == 4'd0);
      w_blank[DIGITS-1-k] = w_lead;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_ovf_pend <= 1'b0;
      r_disp     <= '0;
      r_disp_ovf <= 1'b0;
      r_busy     <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      r_blank    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shift    <= {{BW{1'b0}}, value_in};
            r_ovf_pend <= w_ovf;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_shift <= w_adj << 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_disp     <= r_shift[SW-1 -: BW];
          r_disp_ovf <= r_ovf_pend;
`ifdef LEADING_ZERO_BLANK_EN
          r_blank    <= w_blank;
`endif
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_next = (r_digit == DW'(DIGITS - 1)) ? '0 : r_digit + 1'b1;
  assign w_nib  = r_disp[w_next*4 +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank_sel = r_blank[w_next];
`else
  assign w_blank_sel = 1'b0;
`endif

  assign w_code = (r_disp_ovf || w_blank_sel || (w_nib > 4'd9)) ? 4'hF : w_nib;

  // Code and enable go out at terminal count; the anode follows one cycle later
  // so it lines up with the decoder's registered segment output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh <= '0;
      r_digit   <= '0;
      r_bin     <= '0;
      r_ena     <= 1'b0;
      r_an      <= '1;
    end else begin
      if (r_refresh == RW'(REFRESH_DIV - 1)) begin
        r_refresh <= '0;
        r_digit   <= w_next;
        r_bin     <= w_code;
        r_ena     <= 1'b1;
      end else begin
        r_refresh <= r_refresh + 1'b1;
        r_ena     <= 1'b0;
      end
      if (r_ena) r_an <= ~(DIGITS'(1) << r_digit);
    end
  end

  assign busy     = r_busy;
  assign bin_data = r_bin;
  assign ena      = r_ena;
  assign dig_an   = r_an;

endmodule

// File: tb/tb_pwm_digit_scan.sv
// Directed bench for pwm_digit_scan: a 3-digit and a 2-digit instance, REFRESH_DIV=4.
module tb_pwm_digit_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       load, load2;
  logic [6:0] value_in, value2;
  logic       busy, busy2, ena, ena2;
  logic [3:0] bin_data, bin2;
  logic [2:0] dig_an;
  logic [1:0] dig_an2;

  int n_cmp = 0;
  int n_err = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] Z = 4'hF;
`else
  localparam logic [3:0] Z = 4'h0;
`endif

  always #5 clk = ~clk;

  pwm_digit_scan #(.WIDTH(7), .DIGITS(3), .REFRESH_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in),
    .busy(busy), .bin_data(bin_data), .ena(ena), .dig_an(dig_an)
  );

  pwm_digit_scan #(.WIDTH(7), .DIGITS(2), .REFRESH_DIV(4)) u_dut2 (
    .clk(clk), .rst(rst), .load(load2), .value_in(value2),
    .busy(busy2), .bin_data(bin2), .ena(ena2), .dig_an(dig_an2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic f_ena(input int sel);
    return (sel != 0) ? ena2 : ena;
  endfunction

  function automatic logic [3:0] f_bin(input int sel);
    return (sel != 0) ? bin2 : bin_data;
  endfunction

  function automatic logic [2:0] f_an(input int sel);
    return (sel != 0) ? {1'b1, dig_an2} : dig_an;
  endfunction

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while ((busy === 1'b1 || busy2 === 1'b1) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk(tag, {30'd0, busy2, busy}, 32'd0);
  endtask

  // Observe n consecutive strobes; check code per digit, anode order, pulse width and period.
  task automatic scan_check(input int sel, input int n, input logic [3:0] e0, e1, e2);
    logic [3:0] ev [3];
    logic [3:0] bd;
    logic [2:0] an, an_exp;
    int nd, prev, idx, zeros, t;
    ev[0] = e0; ev[1] = e1; ev[2] = e2;
    nd = (sel != 0) ? 2 : 3;
    prev = -1;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (f_ena(sel) !== 1'b1 && t < 40) begin
        @(negedge clk);
        t++;
      end
      chk("ena_seen", {31'd0, f_ena(sel)}, 32'd1);
      if (f_ena(sel) !== 1'b1) return;
      if (k > 0) chk("ena_period", t + 1, 4);
      bd = f_bin(sel);
      @(negedge clk);
      chk("ena_one_cycle", {31'd0, f_ena(sel)}, 32'd0);
      an = f_an(sel);
      idx = -1;
      zeros = 0;
      for (int j = 0; j < 3; j++) begin
        if (an[j] == 1'b0) begin
          idx = j;
          zeros++;
        end
      end
      chk("an_onehot_low", zeros, 1);
      if (idx < 0 || idx >= nd) return;
      if (prev >= 0) begin
        an_exp = ~(3'b001 << ((prev + 1) % nd));
        chk("an_sequence", {29'd0, an}, {29'd0, an_exp});
      end
      chk("digit_code", {28'd0, bd}, {28'd0, ev[idx]});
      prev = idx;
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; load = 1'b0; load2 = 1'b0; value_in = '0; value2 = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ena", {31'd0, ena}, 32'd0);
    chk("rst_bin", {28'd0, bin_data}, 32'd0);
    chk("rst_an", {29'd0, dig_an}, 32'h7);
    chk("rst_an2", {30'd0, dig_an2}, 32'h3);
    @(negedge clk); rst = 1'b0;

    // Reset in the middle of a conversion must abort it.
    @(negedge clk); load = 1'b1; value_in = 7'd99;
    @(negedge clk); load = 1'b0;
    chk("busy_start", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ena", {31'd0, ena}, 32'd0);
    chk("midrst_bin", {28'd0, bin_data}, 32'd0);
    chk("midrst_an", {29'd0, dig_an}, 32'h7);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("no_commit_busy", {31'd0, busy}, 32'd0);
    scan_check(0, 3, 4'd0, 4'd0, 4'd0);

    // 99: busy for WIDTH+1 cycles, then 9,9,0.
    @(negedge clk); load = 1'b1; value_in = 7'd99;
    @(negedge clk); load = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_len_99", cnt, 8);
    scan_check(0, 3, 4'd9, 4'd9, Z);

    // 127, with an ignored load of 5 while busy.
    @(negedge clk); load = 1'b1; value_in = 7'd127;
    @(negedge clk); load = 1'b0;
    repeat (2) @(negedge clk);
    load = 1'b1; value_in = 7'd5;
    @(negedge clk); load = 1'b0;
    wait_idle("idle_127");
    repeat (3) @(negedge clk);
    chk("load_not_queued", {31'd0, busy}, 32'd0);
    scan_check(0, 3, 4'd7, 4'd2, 4'd1);
    scan_check(0, 6, 4'd7, 4'd2, 4'd1);

    // Two-digit instance: 100 overflows and blanks everything.
    @(negedge clk); load2 = 1'b1; value2 = 7'd100;
    @(negedge clk); load2 = 1'b0;
    chk("busy2_start", {31'd0, busy2}, 32'd1);
    wait_idle("idle_ovf");
    scan_check(1, 4, 4'hF, 4'hF, 4'hF);

    // load held high retriggers right after DONE.
    @(negedge clk); load = 1'b1; value_in = 7'd7;
    @(negedge clk);
    chk("busy_7", {31'd0, busy}, 32'd1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_len_7", cnt, 8);
    @(negedge clk);
    chk("retrigger", {31'd0, busy}, 32'd1);
    load = 1'b0;
    wait_idle("idle_7");
    scan_check(0, 3, 4'd7, Z, Z);

    @(negedge clk); load = 1'b1; value_in = 7'd0;
    @(negedge clk); load = 1'b0;
    wait_idle("idle_0");
    scan_check(0, 3, 4'd0, Z, Z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwm_digit_scan.md
Name: pwm_digit_scan

Overview:
- Upstream feeder for the 7-segment decoder stage. Takes a binary value such as the PWM duty, converts it sequentially to BCD with the shift-add-3 algorithm, and time-multiplexes the digits onto the decoder.
- Drives the decoder's 4-bit digit code and enable, plus the active-low digit (anode) selects, so that segments and anode switch on the same clock edge.

Parameters:
- WIDTH, 7, bit width of value_in.
- DIGITS, 3, number of display digits; digit 0 is least significant.
- REFRESH_DIV, 50000, clock cycles each digit is shown; minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- load  in  1  single-cycle request to convert value_in.
- value_in  in  WIDTH  unsigned binary value to display.
- busy  out  1  high while a conversion is in progress.
- bin_data  out  4  BCD digit code to the decoder; 4'hF means blank.
- ena  out  1  one-cycle strobe to the decoder's enable.
- dig_an  out  DIGITS  digit select, active-low, one-hot-low.

Behaviour:
- Reset (asynchronous, active-high) values:
  - busy=0, bin_data=0, ena=0, dig_an=all 1s.
  - Display register = all-zero digits; overflow flag = 0.
  - Digit index = 0; refresh counter = 0; FSM = IDLE.
- Conversion FSM states:
  - IDLE: a load accepted here captures value_in into the shift register (BCD field cleared) and sets overflow = (value_in >= 10**DIGITS). Next state SHIFT; busy=1 from the following cycle.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift the whole register left by 1. Runs exactly WIDTH cycles. On the last cycle, go to DONE.
  - DONE: one cycle. Copy the BCD field and overflow flag atomically into the display register. busy=0 on the next cycle. Return to IDLE.
- Conversion timing:
  - load accepted at edge N → busy=1 for cycles N+1..N+WIDTH+1.
  - Display register is updated at edge N+WIDTH+1.
- load while busy is ignored and is not queued.
- load held high in IDLE retriggers a conversion after each DONE.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 continuously, independent of conversion. The scan shows the old display register until DONE commits the new one.
  - At terminal count, the digit index advances and wraps from DIGITS-1 to 0, and the counter returns to 0.
  - In that same cycle, register bin_data = code of the new digit and assert ena=1 for exactly one cycle.
  - One cycle later, dig_an drives that digit low and all others high. This matches the decoder's one-cycle register latency.
- Digit code:
  - Overflow flag set: 4'hF on every digit.
  - Otherwise: the BCD nibble of the selected digit.
- Reset mid-conversion: abort; display register returns to zero; nothing is committed.
- Any digit code >= 10 must only ever be 4'hF.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Every zero digit above the most significant nonzero digit outputs 4'hF (blank).
  - Digit 0 is never blanked, so value 0 shows "0" and value 7 shows "  7".
  - The blank pattern is computed at DONE and stored with the display register.
- Undefined: all digits show their BCD value, e.g. "007".
- Overflow blanking applies in both cases.

Test Plan:
- Reset mid-operation: assert rst during SHIFT → all outputs take reset values immediately; after release, the scan shows 0,0,0; the stale conversion is never committed.
- WIDTH=7, DIGITS=3, REFRESH_DIV=4; load with value_in=99 → busy high 8 cycles; subsequent scan gives bin_data 9,9,0 on digits 0,1,2. Each ena is one pulse per 4 cycles, and dig_an goes low one cycle after the matching ena.
- value_in=127 → digits 7,2,1. Then load=1 while busy with value_in=5 → ignored; display still 127.
- Wrap: observe 6 consecutive ena strobes → dig_an sequence 110,101,011,110,101,011.
- DIGITS=2 override, value_in=100 → overflow; every ena carries bin_data=4'hF.
- With LEADING_ZERO_BLANK_EN, value_in=7 → bin_data 7,F,F; value_in=0 → 0,F,F. Without the macro: 7,0,0.
